// File: rtl/spoofer_stream_gen.sv
// Avalon-ST ramp source: per-channel count ramps framed into fixed-length packets,
// free-running or one beat per read_signal edge. Optional macro: SPOOFER_CHANNEL_TAG_EN.
//
// state     | meaning
// IDLE      | no beat offered; clear honoured; mode latched on enable
// WAIT_TRIG | triggered mode, waiting for a synchronised read_signal edge
// SEND      | beat offered on src_valid until accepted
module spoofer_stream_gen #(
  parameter int COUNT_WIDTH  = 24,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter int PACKET_LEN   = 16,
  parameter int STEP         = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   mode,
  input  logic                   clear,
  input  logic [COUNT_WIDTH-1:0] cfg_max,
  input  logic                   read_signal,
  output logic [DATA_WIDTH-1:0]  src_data,
  output logic                   src_valid,
  input  logic                   src_ready,
  output logic [CH_WIDTH-1:0]    src_channel,
  output logic                   src_sop,
  output logic                   src_eop,
  output logic [31:0]            pkt_count,
  output logic [15:0]            trig_dropped
);

  localparam int BEAT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(PACKET_LEN - 1);
  localparam logic [CH_WIDTH-1:0]    LAST_CH   = CH_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [COUNT_WIDTH:0]   STEP_EXT  = (COUNT_WIDTH + 1)'(STEP);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, SEND} state_t;

  state_t                  state;
  logic                    mode_q;
  logic [COUNT_WIDTH-1:0]  ramp [NUM_CHANNELS];
  logic [CH_WIDTH-1:0]     ch_ptr;
  logic [BEAT_W-1:0]       beat_idx;
  logic                    sync1, sync2, sync2_d;

  logic                    trig;
  logic                    accept;
  logic                    last_beat;
  logic [COUNT_WIDTH-1:0]  cur_ramp;
  logic [COUNT_WIDTH:0]    ramp_sum;
  logic [COUNT_WIDTH-1:0]  ramp_next;

  assign trig      = sync2 & ~sync2_d;
  assign accept    = src_valid & src_ready;
  assign last_beat = (beat_idx == LAST_BEAT);

  // Select by compare rather than index so a single-channel build stays width-clean.
  always_comb begin
    cur_ramp = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (ch_ptr == CH_WIDTH'(i)) cur_ramp = ramp[i];
  end

  // Sum carries one extra bit so a ceiling near 2^COUNT_WIDTH-1 cannot alias.
  assign ramp_sum  = {1'b0, cur_ramp} + STEP_EXT;
  assign ramp_next = (ramp_sum > {1'b0, cfg_max}) ? '0 : ramp_sum[COUNT_WIDTH-1:0];

  always_comb begin
    src_data = '0;
    src_data[COUNT_WIDTH-1:0] = cur_ramp;
`ifdef SPOOFER_CHANNEL_TAG_EN
    src_data[DATA_WIDTH-1 -: 8] = 8'(ch_ptr);
`endif
  end

  assign src_channel = ch_ptr;
  assign src_sop     = src_valid & (beat_idx == '0);
  assign src_eop     = src_valid & last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mode_q       <= 1'b0;
      ch_ptr       <= '0;
      beat_idx     <= '0;
      src_valid    <= 1'b0;
      pkt_count    <= '0;
      trig_dropped <= '0;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync2_d      <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) ramp[i] <= '0;
    end else begin
      sync1   <= read_signal;
      sync2   <= sync1;
      sync2_d <= sync2;

      if (trig && (state != WAIT_TRIG) && (trig_dropped != 16'hFFFF))
        trig_dropped <= trig_dropped + 16'd1;

      case (state)
        IDLE: begin
          src_valid <= 1'b0;
          if (clear) begin
            ch_ptr <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) ramp[i] <= '0;
          end
          if (enable) begin
            mode_q <= mode;
            if (mode) begin
              state <= WAIT_TRIG;
            end else begin
              state     <= SEND;
              src_valid <= 1'b1;
            end
          end
        end

        WAIT_TRIG: begin
          if (trig) begin
            state     <= SEND;
            src_valid <= 1'b1;
          end else if (!enable && (beat_idx == '0)) begin
            state <= IDLE;
          end
        end

        SEND: begin
          if (accept) begin
            for (int i = 0; i < NUM_CHANNELS; i++)
              if (ch_ptr == CH_WIDTH'(i)) ramp[i] <= ramp_next;
            if (last_beat) begin
              beat_idx  <= '0;
              ch_ptr    <= (ch_ptr == LAST_CH) ? '0 : ch_ptr + 1'b1;
              pkt_count <= pkt_count + 32'd1;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
            // A disable only takes effect at a packet boundary in free-run mode.
            if (mode_q) begin
              state     <= WAIT_TRIG;
              src_valid <= 1'b0;
            end else if (last_beat && !enable) begin
              state     <= IDLE;
              src_valid <= 1'b0;
            end
          end
        end

        default: begin
          state     <= IDLE;
          src_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spoofer_stream_gen.sv
// Bench for spoofer_stream_gen: default 4-channel instance against a packet-level
// ramp model, plus a 1-channel STEP=2 instance for ceiling wrap sequences.
module tb_spoofer_stream_gen;

  localparam int NCH = 4;
  localparam int PKT = 16;
  localparam int STP = 1;
`ifdef SPOOFER_CHANNEL_TAG_EN
  localparam logic [7:0] TAG_MASK = 8'hFF;
`else
  localparam logic [7:0] TAG_MASK = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, mode, clear, read_signal, src_ready;
  logic [23:0] cfg_max;
  logic [31:0] src_data;
  logic        src_valid, src_sop, src_eop;
  logic [1:0]  src_channel;
  logic [31:0] pkt_count;
  logic [15:0] trig_dropped;

  logic        w_enable, w_clear, w_ready;
  logic [23:0] w_cfg;
  logic [31:0] w_data;
  logic        w_valid, w_sop, w_eop, w_ch;
  logic [31:0] w_pkts;
  logic [15:0] w_drop;

  always #5 clk = ~clk;

  spoofer_stream_gen u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .clear(clear),
    .cfg_max(cfg_max), .read_signal(read_signal), .src_data(src_data),
    .src_valid(src_valid), .src_ready(src_ready), .src_channel(src_channel),
    .src_sop(src_sop), .src_eop(src_eop), .pkt_count(pkt_count),
    .trig_dropped(trig_dropped)
  );

  spoofer_stream_gen #(.NUM_CHANNELS(1), .PACKET_LEN(4), .STEP(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(w_enable), .mode(1'b0), .clear(w_clear),
    .cfg_max(w_cfg), .read_signal(1'b0), .src_data(w_data),
    .src_valid(w_valid), .src_ready(w_ready), .src_channel(w_ch),
    .src_sop(w_sop), .src_eop(w_eop), .pkt_count(w_pkts),
    .trig_dropped(w_drop)
  );

  int          total = 0;
  int          bad   = 0;
  int unsigned m_ramp [NCH];
  int          m_ch, m_beat, accepts;
  int unsigned m_pkts;
  logic [31:0] held;
  int          n0;
  int          exp5 [5] = '{0, 2, 4, 0, 2};
  int          exp4 [4] = '{0, 2, 4, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_word(input int unsigned r, input int c);
    logic [7:0] tag;
    tag = 8'(c) & TAG_MASK;
    return {tag, 24'(r)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) m_ramp[i] = 0;
    m_ch = 0;
  endtask

  // One clock: compare the offered beat with the model, retire it if the sink takes it.
  task automatic tick(input bit rdy);
    src_ready = rdy;
    chk("pkt_count", pkt_count, 32'(m_pkts));
    if (src_valid === 1'b1) begin
      chk("data", src_data, exp_word(m_ramp[m_ch], m_ch));
      chk("channel", 32'(src_channel), 32'(m_ch));
      chk("sop", 32'(src_sop), 32'((m_beat == 0) ? 1 : 0));
      chk("eop", 32'(src_eop), 32'((m_beat == PKT - 1) ? 1 : 0));
      if (rdy) begin
        if (longint'(m_ramp[m_ch]) + STP > longint'(cfg_max)) m_ramp[m_ch] = 0;
        else m_ramp[m_ch] = m_ramp[m_ch] + STP;
        m_beat++;
        if (m_beat == PKT) begin
          m_beat = 0;
          m_ch   = (m_ch + 1) % NCH;
          m_pkts++;
        end
        accepts++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse(input bit rdy);
    read_signal = 1'b1;
    repeat (4) tick(rdy);
    read_signal = 1'b0;
    repeat (6) tick(rdy);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; clear = 1'b0; read_signal = 1'b0;
    src_ready = 1'b0; cfg_max = 24'hFFFFFF;
    w_enable = 1'b0; w_clear = 1'b0; w_ready = 1'b1; w_cfg = 24'd5;
    model_clear();
    m_beat = 0; m_pkts = 0; accepts = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(src_valid), 32'd0);
    chk("rst_sop", 32'(src_sop), 32'd0);
    chk("rst_eop", 32'(src_eop), 32'd0);
    chk("rst_data", src_data, 32'd0);
    chk("rst_pkts", pkt_count, 32'd0);
    chk("rst_drop", 32'(trig_dropped), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ceiling wrap with STEP=2 on the single-channel instance
    w_enable = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("wrap5_valid", 32'(w_valid), 32'd1);
      chk("wrap5_data", w_data, 32'(exp5[i]));
      @(posedge clk); #1;
    end
    w_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (w_valid !== 1'b1) break;
      @(posedge clk); #1;
    end
    chk("wrap_idle", 32'(w_valid), 32'd0);
    w_clear = 1'b1;
    @(posedge clk); #1;
    w_clear = 1'b0; w_cfg = 24'd4; w_enable = 1'b1;
    @(posedge clk); #1;
    w_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wrap4_data", w_data, 32'(exp4[i]));
      @(posedge clk); #1;
    end
    chk("wrap4_idle", 32'(w_valid), 32'd0);

    // Free-run: four full packets round-robin, then ch0 resumes at 16
    mode = 1'b0; enable = 1'b1; src_ready = 1'b1;
    @(posedge clk); #1;
    chk("lat_mode0", 32'(src_valid), 32'd1);
    repeat (64) tick(1'b1);
    chk("pkts_after_64", pkt_count, 32'd4);
    chk("ch0_resume", src_data & 32'h00FF_FFFF, 32'd16);
    chk("ch0_resume_ch", 32'(src_channel), 32'd0);

    // Backpressure mid-packet
    repeat (3) tick(1'b1);
    held = src_data;
    repeat (5) begin
      tick(1'b0);
      chk("hold_data", src_data, held);
    end

    // Random ready with a changing, mostly small ceiling
    for (int i = 0; i < 200; i++) begin
      if (i % 25 == 0) cfg_max = (i < 150) ? 24'($urandom_range(3, 40)) : 24'hFFFFFF;
      chk("run_valid", 32'(src_valid), 32'd1);
      tick($urandom_range(0, 3) != 0);
    end

    // Disable after beat 7: the rest of the packet still goes out
    for (int i = 0; i < 40 && m_beat != 8; i++) tick(1'b1);
    if (m_beat != 8) begin
      bad++;
      $error("FAIL timeout_beat7 observed=%0d expected=8", m_beat);
    end
    enable = 1'b0;
    n0 = accepts;
    for (int i = 0; i < 40; i++) begin
      if (src_valid !== 1'b1) break;
      tick(1'b1);
    end
    chk("tail_beats", 32'(accepts - n0), 32'd8);
    chk("idle_valid", 32'(src_valid), 32'd0);
    repeat (3) tick(1'b1);
    chk("idle_stays", 32'(src_valid), 32'd0);

    // Clear in IDLE restarts at ch0 / value 0
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    chk("clr_valid", 32'(src_valid), 32'd1);
    chk("clr_data", src_data, 32'd0);
    chk("clr_ch", 32'(src_channel), 32'd0);
    chk("clr_sop", 32'(src_sop), 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (src_valid !== 1'b1) break;
      tick(1'b1);
    end
    chk("clr_pkt_idle", 32'(src_valid), 32'd0);

    // Triggered mode: three consumed edges, one dropped while a beat is pending
    mode = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    chk("wait_valid", 32'(src_valid), 32'd0);
    n0 = accepts;
    pulse(1'b1);
    pulse(1'b1);
    pulse(1'b0);
    chk("pending_valid", 32'(src_valid), 32'd1);
    pulse(1'b0);
    repeat (4) tick(1'b1);
    chk("trig_beats", 32'(accepts - n0), 32'd3);
    chk("trig_dropped", 32'(trig_dropped), 32'd1);

    // Async reset with a beat pending
    pulse(1'b0);
    chk("pre_rst_valid", 32'(src_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(src_valid), 32'd0);
    chk("arst_sop", 32'(src_sop), 32'd0);
    chk("arst_eop", 32'(src_eop), 32'd0);
    chk("arst_data", src_data, 32'd0);
    chk("arst_pkts", pkt_count, 32'd0);
    chk("arst_drop", 32'(trig_dropped), 32'd0);
    chk("arst_ch", 32'(src_channel), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
